// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown block.
package bcd_pkg;
   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;
endpackage

// File: rtl/bcd_countdown_if.sv
// Control/status bundle between a countdown user (master) and the counter (slave).
interface bcd_countdown_if #(parameter int DIGITS = 4);
   import bcd_pkg::*;

   logic                      load;
   logic [DIGIT_W*DIGITS-1:0] load_value;
   logic                      enable;
   logic [DIGIT_W*DIGITS-1:0] count;
   logic                      zero;
   logic                      busy;
   logic                      done;

   modport master (output load, load_value, enable, input count, zero, busy, done);
   modport slave  (input load, load_value, enable, output count, zero, busy, done);
endinterface

// File: rtl/bcd_digit_dec.sv
// Combinational single-digit BCD decrement with borrow chaining.
module bcd_digit_dec
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] digit_out,
   output logic               borrow_out
);
   logic is_zero;

   assign is_zero    = (digit == '0);
   assign borrow_out = borrow_in & is_zero;

   always_comb begin
      digit_out = digit;
      if (borrow_in) digit_out = is_zero ? DIGIT_MAX : digit - 4'd1;
   end
endmodule

// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD down-counter with expiry pulse and optional auto-reload.
module bcd_countdown
   import bcd_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic clk,
   input  logic reset,
   bcd_countdown_if.slave bus
);
   localparam int W = DIGIT_W * DIGITS;
   localparam logic [W-1:0] ONE = W'(1);

   state_t         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   reload_q, reload_d;
   logic           done_q, done_d;
   logic [W-1:0]   san_val, dec_val;
   logic [DIGITS:0] borrow;

   assign borrow[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign san_val[g*DIGIT_W +: DIGIT_W] =
         (bus.load_value[g*DIGIT_W +: DIGIT_W] > DIGIT_MAX) ? DIGIT_MAX
                                                            : bus.load_value[g*DIGIT_W +: DIGIT_W];

      bcd_digit_dec u_dec (
         .digit      (count_q[g*DIGIT_W +: DIGIT_W]),
         .borrow_in  (borrow[g]),
         .digit_out  (dec_val[g*DIGIT_W +: DIGIT_W]),
         .borrow_out (borrow[g+1])
      );
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (bus.load) begin
         count_d  = san_val;
         reload_d = san_val;
         state_d  = (san_val == '0) ? ST_EXPIRED : ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (count_q == '0) begin
                  state_d = ST_EXPIRED;
               end else if (bus.enable) begin
                  count_d = dec_val;
                  if (count_q == ONE) begin
                     state_d = ST_EXPIRED;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_EXPIRED: begin
               // A zero reload value parks here for good rather than re-expiring.
               if (AUTO_RELOAD && bus.enable && reload_q != '0) begin
                  count_d = reload_q;
                  state_d = ST_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign bus.count = count_q;
   // The final borrow out of the chain is set exactly when every digit is zero.
   assign bus.zero  = borrow[DIGITS];
   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = done_q;
endmodule

// File: tb/tb_bcd_countdown.sv
// Directed checks for bcd_countdown at DIGITS=2, one instance per AUTO_RELOAD setting.
module tb_bcd_countdown;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bcd_countdown_if #(.DIGITS(2)) bus0 ();
   bcd_countdown_if #(.DIGITS(2)) bus1 ();

   bcd_countdown #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
   bcd_countdown #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic test_reset();
      bus0.load = 0; bus0.load_value = '0; bus0.enable = 0;
      bus1.load = 0; bus1.load_value = '0; bus1.enable = 0;
      #12;
      total++; if (bus0.count !== 8'h00 || bus0.zero !== 1'b1 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
         bad++; $display("FAIL reset_init: count=%h zero=%b busy=%b done=%b want 00/1/0/0", bus0.count, bus0.zero, bus0.busy, bus0.done); end
      reset = 0;
      step();
      // idle ignores enable
      bus0.enable = 1;
      repeat (5) step();
      total++; if (bus0.count !== 8'h00 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
         bad++; $display("FAIL idle_enable: count=%h busy=%b done=%b want 00/0/0", bus0.count, bus0.busy, bus0.done); end
      bus0.enable = 0;
      bus0.load = 1; bus0.load_value = 8'h37;
      step();
      bus0.load = 0;
      total++; if (bus0.count !== 8'h37 || bus0.busy !== 1'b1) begin
         bad++; $display("FAIL load_37: count=%h busy=%b want 37/1", bus0.count, bus0.busy); end
      #2 reset = 1;
      #1;
      total++; if (bus0.count !== 8'h00 || bus0.zero !== 1'b1 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
         bad++; $display("FAIL reset_async: count=%h zero=%b busy=%b done=%b want 00/1/0/0", bus0.count, bus0.zero, bus0.busy, bus0.done); end
      step();
      #2 reset = 0;
   endtask

   task automatic test_borrow();
      int pulses = 0;
      bus0.load = 1; bus0.load_value = 8'h20; bus0.enable = 0;
      step();
      total++; if (bus0.count !== 8'h20 || bus0.busy !== 1'b1 || bus0.zero !== 1'b0) begin
         bad++; $display("FAIL borrow_load: count=%h busy=%b zero=%b want 20/1/0", bus0.count, bus0.busy, bus0.zero); end
      bus0.load = 0; bus0.enable = 1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus0.done === 1'b1) pulses++;
         total++; if (bus0.count !== to_bcd(20 - i) || bus0.done !== (i == 20)) begin
            bad++; $display("FAIL borrow_seq[%0d]: count=%h done=%b want %h/%b", i, bus0.count, bus0.done, to_bcd(20 - i), (i == 20)); end
      end
      total++; if (pulses != 1 || bus0.zero !== 1'b1 || bus0.busy !== 1'b0) begin
         bad++; $display("FAIL borrow_end: pulses=%0d zero=%b busy=%b want 1/1/0", pulses, bus0.zero, bus0.busy); end
   endtask

   task automatic test_expiry_hold();
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus0.done === 1'b1) pulses++;
         total++; if (bus0.count !== 8'h00 || bus0.busy !== 1'b0) begin
            bad++; $display("FAIL expiry_hold[%0d]: count=%h busy=%b want 00/0", i, bus0.count, bus0.busy); end
      end
      total++; if (pulses != 0) begin
         bad++; $display("FAIL expiry_extra_done: pulses=%0d want 0", pulses); end
      bus0.enable = 0;
   endtask

   task automatic test_sanitise_hold();
      bus0.load = 1; bus0.load_value = 8'hAF; bus0.enable = 0;
      step();
      bus0.load = 0;
      total++; if (bus0.count !== 8'h99) begin
         bad++; $display("FAIL sanitise: count=%h want 99", bus0.count); end
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (bus0.count !== 8'h99 || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
            bad++; $display("FAIL hold[%0d]: count=%h busy=%b done=%b want 99/1/0", i, bus0.count, bus0.busy, bus0.done); end
      end
      bus0.enable = 1;
      step();
      total++; if (bus0.count !== 8'h98) begin
         bad++; $display("FAIL resume_dec: count=%h want 98", bus0.count); end
      bus0.enable = 0;
   endtask

   task automatic test_priority_zero();
      bus0.load = 1; bus0.load_value = 8'h05; bus0.enable = 1;
      step();
      total++; if (bus0.count !== 8'h05 || bus0.busy !== 1'b1) begin
         bad++; $display("FAIL priority: count=%h busy=%b want 05/1", bus0.count, bus0.busy); end
      bus0.load_value = 8'h00;
      step();
      bus0.load = 0;
      total++; if (bus0.count !== 8'h00 || bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.zero !== 1'b1) begin
         bad++; $display("FAIL zero_load: count=%h done=%b busy=%b zero=%b want 00/0/0/1", bus0.count, bus0.done, bus0.busy, bus0.zero); end
      step();
      total++; if (bus0.count !== 8'h00 || bus0.done !== 1'b0) begin
         bad++; $display("FAIL zero_load_after: count=%h done=%b want 00/0", bus0.count, bus0.done); end
      bus0.enable = 0;
      // auto-reload instance: zero reload value parks with no done
      bus1.load = 1; bus1.load_value = 8'h00; bus1.enable = 1;
      step();
      bus1.load = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bus1.count !== 8'h00 || bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
            bad++; $display("FAIL ar_zero[%0d]: count=%h done=%b busy=%b want 00/0/0", i, bus1.count, bus1.done, bus1.busy); end
      end
      bus1.enable = 0;
   endtask

   task automatic test_auto_reload();
      logic [7:0] seq [4] = '{8'h03, 8'h02, 8'h01, 8'h00};
      int pulses = 0;
      bus1.load = 1; bus1.load_value = 8'h03; bus1.enable = 1;
      step();
      bus1.load = 0;
      total++; if (bus1.count !== 8'h03 || bus1.busy !== 1'b1) begin
         bad++; $display("FAIL ar_load: count=%h busy=%b want 03/1", bus1.count, bus1.busy); end
      for (int i = 1; i <= 12; i++) begin
         step();
         if (bus1.done === 1'b1) pulses++;
         total++; if (bus1.count !== seq[i % 4] || bus1.done !== ((i % 4) == 3)) begin
            bad++; $display("FAIL ar_seq[%0d]: count=%h done=%b want %h/%b", i, bus1.count, bus1.done, seq[i % 4], ((i % 4) == 3)); end
      end
      total++; if (pulses != 3) begin
         bad++; $display("FAIL ar_pulses: got=%0d want 3", pulses); end
      bus1.enable = 0;
   endtask

   initial begin
      test_reset();
      test_borrow();
      test_expiry_hold();
      test_sanitise_hold();
      test_priority_zero();
      test_auto_reload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 SHALL have parameter AUTO_RELOAD, default 0: 1 restarts the countdown from the last loaded value after expiry.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  captures load_value this cycle.
REQ-006 SHALL have port load_value  input  4*DIGITS  packed BCD start value; digit 0 is in bits [3:0].
REQ-007 SHALL have port enable  input  1  permits one decrement per cycle.
REQ-008 SHALL have port count  output  4*DIGITS  registered packed BCD current value.
REQ-009 SHALL have port zero  output  1  high whenever count equals 0; derived from the count register only.
REQ-010 SHALL have port busy  output  1  high when the FSM is in RUN.
REQ-011 SHALL have port done  output  1  registered one-cycle pulse on expiry.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and EXPIRED.
REQ-013 SHALL sanitise load_value per digit: any digit greater than 9 becomes 9.
REQ-014 SHALL, on load in any state, set count and an internal reload register to the sanitised value in the next cycle, with next state RUN if the value is nonzero and EXPIRED if it is zero.
REQ-015 SHALL NOT pulse done when a zero value is loaded.
REQ-016 SHALL give load priority over enable when both are high in the same cycle; no decrement occurs that cycle.
REQ-017 SHALL, in RUN with enable=1, decrement count by 1 in BCD: digit 0 wraps to 9 and borrows from the next digit; latency is 1 cycle.
REQ-018 SHALL, in RUN with enable=0, hold count.
REQ-019 SHALL, when count goes 1 -> 0 in RUN, move to EXPIRED and assert done for exactly the cycle in which count first reads 0.
REQ-020 SHALL, in IDLE or EXPIRED with AUTO_RELOAD=0, ignore enable and hold count at its value with no wrap to 99..9.
REQ-021 SHALL, in EXPIRED with AUTO_RELOAD=1 and enable=1, copy the reload register to count and enter RUN; a reload value of 0 stays in EXPIRED with no further done pulses.
REQ-022 SHALL leave IDLE only through load.
REQ-023 SHALL never drive a digit value greater than 9 on count.

Reset
REQ-024 SHALL, on reset assertion, immediately and without a clock set count=0, the reload register=0, done=0, and the state to IDLE.
REQ-025 SHALL therefore read busy=0 and zero=1 during and after reset.
REQ-026 SHALL abandon any countdown in progress on mid-operation reset, with no done pulse.
REQ-027 SHALL take the first load at the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place the FSM state enumeration, the BCD digit width (4) and the maximum digit value (9) in a shared package, bcd_pkg.
REQ-029 SHALL use one sub-module, bcd_digit_dec: a combinational single-digit decrement taking digit and borrow_in and producing digit_out and borrow_out, instantiated DIGITS times in a borrow chain.

Verification
All scenarios use DIGITS=2.
REQ-030 SHALL cover reset: assert reset mid-count at 0x37 -> count=0x00, zero=1, busy=0, done=0 immediately, without a clock edge.
REQ-031 SHALL cover borrow: load 0x20, enable held -> count 0x19, 0x18, ... 0x10, 0x09 ... 0x01, 0x00; done pulses once, in the 0x00 cycle, 20 cycles after the load takes effect.
REQ-032 SHALL cover sanitisation and hold: load 0xAF -> count=0x99; enable low for 5 cycles -> count stays 0x99 and busy=1.
REQ-033 SHALL cover priority and zero load: load 0x05 with enable=1 in the same cycle -> count=0x05, not 0x04; load 0x00 -> state EXPIRED, done stays 0.
REQ-034 SHALL cover expiry hold with AUTO_RELOAD=0: after reaching 0x00, 10 further enabled cycles -> count stays 0x00 with a single done pulse.
REQ-035 SHALL cover auto-reload with AUTO_RELOAD=1: load 0x03, enable held -> 0x03, 0x02, 0x01, 0x00 (done), 0x03, 0x02, ...; done period is 4 cycles.
